// File: rtl/relu_bp_pkg.sv
// Shared defaults and the forward-activation mask computation for the ReLU
// backprop datapath.
package relu_bp_pkg;

    localparam int unsigned DEF_BITWIDTH  = 8;
    localparam int unsigned DEF_LENGTH    = 4;
    localparam int signed   DEF_THRESHOLD = 0;
    localparam int unsigned DEF_DEPTH     = 4;

    localparam int unsigned MAX_BITWIDTH = 32;
    localparam int unsigned MAX_LENGTH   = 64;
    localparam int unsigned MAX_VEC      = MAX_BITWIDTH * MAX_LENGTH;

    typedef logic [MAX_VEC-1:0]    vec_t;
    typedef logic [MAX_LENGTH-1:0] mask_t;

    // Callers zero-extend their packed vector into vec_t and truncate the result;
    // each element is sign-extended to MAX_BITWIDTH before the signed compare.
    function automatic mask_t relu_mask(
        input vec_t        vec,
        input int signed   thr,
        input int unsigned len,
        input int unsigned bw
    );
        mask_t                          m;
        logic signed [MAX_BITWIDTH-1:0] elem;
        m    = '0;
        elem = '0;
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            if (i < len) begin
                for (int unsigned b = 0; b < MAX_BITWIDTH; b++) begin
                    elem[b] = (b < bw) ? vec[i*bw + b] : vec[i*bw + bw - 1];
                end
                m[i] = (elem > thr);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Circular FIFO holding one ReLU activation mask per forward vector until its
// matching gradient arrives.
module relu_mask_fifo
    import relu_bp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_LENGTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == DEPTH_C);
    assign empty = (r_count == '0);

    // Storage is intentionally left out of reset; only pointers/count qualify it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/vector_relu_backprop.sv
// ReLU backward pass: records a sign mask per forward vector and gates each
// incoming gradient vector by its oldest stored mask, with a registered output.
module vector_relu_backprop
    import relu_bp_pkg::*;
#(
    parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
    parameter int unsigned LENGTH    = DEF_LENGTH,
    parameter int signed   THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         fwd_valid,
    output logic                         fwd_ready,
    input  logic [LENGTH*BITWIDTH-1:0]   fwd_data,
    input  logic                         grad_valid,
    output logic                         grad_ready,
    input  logic [LENGTH*BITWIDTH-1:0]   grad_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LENGTH*BITWIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]   mask_count
);

    localparam int unsigned VW = LENGTH * BITWIDTH;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic              w_fwd_xfer;
    logic              w_grad_xfer;
    logic              w_full;
    logic              w_empty;
    logic [LENGTH-1:0] w_fwd_mask;
    logic [LENGTH-1:0] w_rd_mask;
    logic [VW-1:0]     w_gated;
    logic [CW-1:0]     w_count;
    logic              r_out_valid;
    logic [VW-1:0]     r_out_data;

    assign w_fwd_mask = LENGTH'(relu_mask(vec_t'(fwd_data), THRESHOLD, LENGTH, BITWIDTH));

    // Readies come from registered FIFO occupancy, so flush never affects them
    // within its own cycle and a full FIFO refuses a push even alongside a pop.
    assign fwd_ready   = !w_full;
    assign grad_ready  = !w_empty && (!r_out_valid || out_ready);
    assign w_fwd_xfer  = fwd_valid && fwd_ready;
    assign w_grad_xfer = grad_valid && grad_ready;

    relu_mask_fifo #(
        .WIDTH (LENGTH),
        .DEPTH (DEPTH)
    ) u_mask_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_fwd_xfer),
        .wdata (w_fwd_mask),
        .pop   (w_grad_xfer),
        .rdata (w_rd_mask),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_gated = '0;
        for (int unsigned i = 0; i < LENGTH; i++) begin
            if (w_rd_mask[i]) begin
                w_gated[i*BITWIDTH +: BITWIDTH] = grad_data[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_grad_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gated;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign mask_count = w_count;

endmodule

// File: tb/tb_vector_relu_backprop.sv
// Randomised and directed checks of vector_relu_backprop against a queue-based
// reference model of the mask FIFO and gated output register.
module tb_vector_relu_backprop;

    localparam int BW    = 8;
    localparam int LEN   = 4;
    localparam int DEPTH = 4;
    localparam int VW    = BW * LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [VW-1:0] fwd_data;
    logic          grad_valid;
    logic          grad_ready;
    logic [VW-1:0] grad_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [2:0]    mask_count;

    int n_checks = 0;
    int n_fail   = 0;

    int            mq[$];
    logic          m_ov;
    logic [VW-1:0] m_od;
    logic [VW-1:0] saved;

    vector_relu_backprop #(
        .BITWIDTH  (BW),
        .LENGTH    (LEN),
        .THRESHOLD (0),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fwd_valid  (fwd_valid),
        .fwd_ready  (fwd_ready),
        .fwd_data   (fwd_data),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_data  (grad_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mask_count (mask_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdl_mask(input logic [VW-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < LEN; i++) begin
            byte e;
            e = v[i*BW +: BW];
            if (int'(e) > 0) r = r | (1 << i);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] gate(input int m, input logic [VW-1:0] g);
        logic [VW-1:0] res;
        res = '0;
        for (int i = 0; i < LEN; i++) begin
            if (m[i]) res[i*BW +: BW] = g[i*BW +: BW];
        end
        return res;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        logic [7:0]    e;
        for (int i = 0; i < LEN; i++) begin
            case ($urandom_range(0, 5))
                0:       e = 8'h80;
                1:       e = 8'hFF;
                2:       e = 8'h00;
                3:       e = 8'h01;
                4:       e = 8'h7F;
                default: e = 8'($urandom);
            endcase
            v[i*BW +: BW] = e;
        end
        return v;
    endfunction

    task automatic idle();
        fwd_valid  = 1'b0;
        grad_valid = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        m_od = '0;
    endtask

    // Called at posedge+1 with inputs driven; checks, advances the model, and
    // returns at the next posedge+1.
    task automatic cycle();
        bit efr, egr;
        int m;
        #1;
        efr = (mq.size() < DEPTH);
        egr = (mq.size() != 0) && (!m_ov || out_ready);
        check("fwd_ready",  fwd_ready,  efr);
        check("grad_ready", grad_ready, egr);
        check("out_valid",  out_valid,  m_ov);
        check("out_data",   out_data,   m_od);
        check("mask_count", mask_count, mq.size());
        if (flush) begin
            model_reset();
        end else begin
            if (grad_valid && egr) begin
                m    = mq.pop_front();
                m_ov = 1'b1;
                m_od = gate(m, grad_data);
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (fwd_valid && efr) mq.push_back(mdl_mask(fwd_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        grad_valid = 1'b1;
        grad_data  = rnd_vec();
        for (int i = 0; i < DEPTH + 2; i++) begin
            grad_data = rnd_vec();
            cycle();
        end
        idle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        fwd_data  = '0;
        grad_data = '0;
        rst       = 1'b1;
        #1;
        check("reset_out_valid",  out_valid,  1'b0);
        check("reset_out_data",   out_data,   '0);
        check("reset_mask_count", mask_count, 3'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reference vector: {-3,0,1,127} gating {10,20,30,40}
        fwd_valid = 1'b1;
        fwd_data  = {8'd127, 8'd1, 8'd0, 8'hFD};
        cycle();
        fwd_valid  = 1'b0;
        grad_valid = 1'b1;
        grad_data  = {8'd40, 8'd30, 8'd20, 8'd10};
        cycle();
        grad_valid = 1'b0;
        check("ref_out_data",  out_data,  {8'd40, 8'd30, 8'd0, 8'd0});
        check("ref_out_valid", out_valid, 1'b1);
        cycle();

        // Fill to DEPTH, then a refused push alongside a pop
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data = rnd_vec();
            cycle();
        end
        fwd_valid = 1'b0;
        check("full_fwd_ready",  fwd_ready,  1'b0);
        check("full_mask_count", mask_count, 3'd4);
        fwd_valid  = 1'b1;
        fwd_data   = rnd_vec();
        grad_valid = 1'b1;
        grad_data  = rnd_vec();
        cycle();
        check("full_pushpop_count", mask_count, 3'd3);
        drain();

        // Empty FIFO must ignore gradients
        grad_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            grad_data = rnd_vec();
            check("empty_grad_ready", grad_ready, 1'b0);
            check("empty_out_valid",  out_valid,  1'b0);
            cycle();
        end
        idle();

        // Output stall holds data and blocks the next pop
        fwd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fwd_data = rnd_vec();
            cycle();
        end
        fwd_valid  = 1'b0;
        grad_valid = 1'b1;
        out_ready  = 1'b0;
        grad_data  = {8'h7F, 8'h80, 8'h33, 8'hC1};
        cycle();
        saved = m_od;
        for (int i = 0; i < 3; i++) begin
            grad_data = rnd_vec();
            check("stall_out_data",   out_data,   saved);
            check("stall_grad_ready", grad_ready, 1'b0);
            check("stall_mask_count", mask_count, 3'd1);
            cycle();
        end
        drain();

        // Interleaved push/pop wraps both pointers
        for (int i = 0; i < 6; i++) begin
            idle();
            fwd_valid = 1'b1;
            fwd_data  = rnd_vec();
            cycle();
            idle();
            grad_valid = 1'b1;
            grad_data  = rnd_vec();
            cycle();
        end
        drain();

        // Flush with two masks stored and a stalled output
        fwd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwd_data = rnd_vec();
            cycle();
        end
        idle();
        grad_valid = 1'b1;
        out_ready  = 1'b0;
        grad_data  = rnd_vec();
        cycle();
        grad_valid = 1'b0;
        check("preflush_count", mask_count, 3'd2);
        check("preflush_valid", out_valid,  1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_count", mask_count, 3'd0);
        check("flush_valid", out_valid,  1'b0);
        out_ready = 1'b1;
        fwd_valid = 1'b1;
        fwd_data  = rnd_vec();
        cycle();
        idle();
        grad_valid = 1'b1;
        grad_data  = rnd_vec();
        cycle();
        idle();
        cycle();

        // Asynchronous reset with two masks stored and a stalled output
        fwd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwd_data = rnd_vec();
            cycle();
        end
        idle();
        grad_valid = 1'b1;
        out_ready  = 1'b0;
        grad_data  = rnd_vec();
        cycle();
        grad_valid = 1'b0;
        check("prerst_count", mask_count, 3'd2);
        check("prerst_valid", out_valid,  1'b1);
        rst = 1'b1;
        #1;
        check("rst_count", mask_count, 3'd0);
        check("rst_valid", out_valid,  1'b0);
        check("rst_data",  out_data,   '0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        fwd_valid = 1'b1;
        fwd_data  = rnd_vec();
        cycle();
        check("postrst_count", mask_count, 3'd1);
        idle();
        grad_valid = 1'b1;
        grad_data  = rnd_vec();
        cycle();
        idle();
        cycle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            fwd_valid  = ($urandom_range(0, 99) < 55);
            grad_valid = ($urandom_range(0, 99) < 50);
            out_ready  = ($urandom_range(0, 99) < 70);
            flush      = ($urandom_range(0, 99) < 3);
            fwd_data   = rnd_vec();
            grad_data  = rnd_vec();
            cycle();
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_relu_backprop.md
VECTOR_RELU_BACKPROP -- requirements
Module: vector_relu_backprop

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8, meaning element width in bits, signed two's complement.
REQ-002 The block SHALL have parameter LENGTH, default 4, meaning elements per vector.
REQ-003 The block SHALL have parameter THRESHOLD, default 0, meaning the signed forward-activation threshold.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the number of mask-FIFO entries; it is a power of two and at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset; it is asynchronous and active-high.
REQ-007 The block SHALL have port flush, input, 1 bit, meaning synchronous discard of all stored masks and of the output register.
REQ-008 The block SHALL have port fwd_valid, input, 1 bit, meaning a forward pre-activation vector is present.
REQ-009 The block SHALL have port fwd_ready, output, 1 bit, meaning the block will accept fwd_data this cycle.
REQ-010 The block SHALL have port fwd_data, input, LENGTH x BITWIDTH signed, meaning the forward pre-activation vector.
REQ-011 The block SHALL have port grad_valid, input, 1 bit, meaning an upstream gradient vector is present.
REQ-012 The block SHALL have port grad_ready, output, 1 bit, meaning the block will accept grad_data this cycle.
REQ-013 The block SHALL have port grad_data, input, LENGTH x BITWIDTH signed, meaning the upstream gradient vector.
REQ-014 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a gated gradient.
REQ-015 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_data.
REQ-016 The block SHALL have port out_data, output, LENGTH x BITWIDTH signed, meaning the gated gradient vector.
REQ-017 The block SHALL have port mask_count, output, $clog2(DEPTH+1) bits, meaning the number of stored masks.

Function
REQ-018 Forward transfer = fwd_valid && fwd_ready; it SHALL push a LENGTH-bit mask, bit i = (fwd_data[i] > THRESHOLD), with the comparison signed.
REQ-019 fwd_ready SHALL equal (mask_count < DEPTH) and depend on registered state only, so no push occurs when full, even if a pop occurs in the same cycle.
REQ-020 grad_ready SHALL equal (mask_count != 0) && (!out_valid || out_ready); there is no bypass path from forward to gradient when the FIFO is empty.
REQ-021 A gradient transfer SHALL pop the oldest mask (FIFO order) and register out_data[i] = mask[i] ? grad_data[i] : 0 on the same edge, so latency is 1 cycle.
REQ-022 On the edge of a gradient transfer out_valid SHALL be set to 1; out_valid SHALL clear on out_ready when no new transfer occurs on that edge.
REQ-023 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-024 A simultaneous push and pop SHALL leave mask_count unchanged and advance both pointers.
REQ-025 The read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 flush SHALL take priority over all transfers: mask_count, both pointers and out_valid go to 0 on that edge, and fwd_ready and grad_ready are unaffected combinationally within that cycle.
REQ-027 Gradient values SHALL pass through bit-exact with no saturation or width change.

Reset
REQ-028 rst asserted SHALL immediately force out_valid=0, out_data=all 0, mask_count=0 and both pointers to 0; mask storage contents need not reset.
REQ-029 rst asserted mid-stall SHALL drop out_valid without waiting for out_ready, and the first transfer SHALL be possible on the first rising edge after deassertion.

Structure
REQ-030 Package relu_bp_pkg SHALL hold the default parameter values and a mask-compute function (vector, threshold) -> LENGTH-bit mask.
REQ-031 Mask storage SHALL be one sub-module, relu_mask_fifo (width LENGTH, depth DEPTH, push/pop/count/flush); gating and output register SHALL remain in the top module.

Verification
REQ-032 With fwd={-3,0,1,127} and THRESHOLD=0, pushed then followed by grad={10,20,30,40}, the bench SHALL see out_data={0,0,30,40} one cycle after the gradient transfer.
REQ-033 After pushing 4 masks with DEPTH=4, the bench SHALL see fwd_ready=0 and mask_count=4; with a simultaneous fwd_valid and grad transfer, mask_count SHALL be 3 next cycle and no push occurs.
REQ-034 With an empty FIFO and grad_valid=1 for 5 cycles, the bench SHALL see grad_ready=0 throughout and out_valid=0.
REQ-035 With out_ready=0 for 3 cycles after an output, the bench SHALL see out_data stable, grad_ready=0, and the next mask not consumed.
REQ-036 Pushing 6 masks and popping 6 in an interleaved pattern with DEPTH=4 SHALL wrap the pointers, and every output SHALL match its paired mask in order.
REQ-037 With rst or flush at mask_count=2 and out_valid=1, the bench SHALL see mask_count=0, out_valid=0, and the following push/pop pair SHALL operate correctly.
